// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants, state and op encodings for the shared data-memory responder
package dmem_pkg;
  localparam int N_CORES = 8;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int DEPTH = 256;
  typedef enum logic [1:0] {ARB = 2'd0, ACC = 2'd1, RSP = 2'd2} state_t;
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, first requester at or after ptr
module rr_arbiter #(
  parameter int N = 8,
  parameter int GW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  output logic          gnt_valid,
  output logic [GW-1:0] gnt
);
  always_comb begin
    gnt_valid = |req;
    gnt = '0;
    // scan farthest-first so the requester nearest ptr overwrites last
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) gnt = GW'((int'(ptr) + k) % N);
  end
endmodule

// File: rtl/shared_dmem_responder.sv
// shared_dmem_responder: serialises per-core data-memory requests onto one shared word array
module shared_dmem_responder #(
  parameter int N_CORES = dmem_pkg::N_CORES,
  parameter int AW = dmem_pkg::AW,
  parameter int DW = dmem_pkg::DW,
  parameter int DEPTH = dmem_pkg::DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CORES-1:0]    core_dmr,
  input  logic [N_CORES-1:0]    core_dmw,
  input  logic [N_CORES*AW-1:0] core_ar,
  input  logic [N_CORES*DW-1:0] core_dr,
  input  logic [N_CORES-1:0]    core_fin,
  output logic [N_CORES*DW-1:0] core_dm,
  output logic [N_CORES-1:0]    core_ack,
  output logic                  busy,
  output logic                  all_done
);
  import dmem_pkg::*;
  localparam int GW = $clog2(N_CORES);
  localparam int IW = $clog2(DEPTH);
  state_t state, state_n;
  logic [GW-1:0] rr_ptr, gnt, arb_gnt;
  logic arb_valid, op;
  logic [IW-1:0] idx;
  logic [DW-1:0] wdata;
  logic [DW-1:0] mem [DEPTH];
  logic unused_ar;
  assign unused_ar = ^core_ar;
  rr_arbiter #(.N(N_CORES)) u_arb (
    .req(core_dmr | core_dmw),
    .ptr(rr_ptr),
    .gnt_valid(arb_valid),
    .gnt(arb_gnt)
  );
  always_comb state_n = state == ARB ? (arb_valid ? ACC : ARB) : state == ACC ? RSP : ARB;
  assign busy = state != ARB;
  // gated by rst so a reset asserted during the response cycle suppresses the ack
  assign core_ack = (state == RSP && rst) ? N_CORES'(1) << gnt : '0;
  always_ff @(posedge clk) begin
    all_done <= rst & (&core_fin);
    if (!rst) begin
      state <= ARB;
      rr_ptr <= '0;
      core_dm <= '0;
    end else begin
      state <= state_n;
      if (state == ARB && arb_valid) begin
        gnt <= arb_gnt;
        idx <= core_ar[arb_gnt*AW +: IW];
        wdata <= core_dr[arb_gnt*DW +: DW];
        op <= core_dmw[arb_gnt] ? OP_WR : OP_RD;
      end
      if (state == ACC && op == OP_RD) core_dm[gnt*DW +: DW] <= mem[idx];
      if (state == RSP) rr_ptr <= (gnt == GW'(N_CORES - 1)) ? '0 : gnt + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (rst && state == ACC && op == OP_WR) mem[idx] <= wdata;
endmodule
